// File: rtl/letc_core_iter_comparator.sv
`default_nettype none
// ============================================================================
// Module   : letc_core_iter_comparator
// Purpose  : Multi-cycle branch/CSR comparator. Evaluates one comparison on
//            two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and
//            stops at the first differing slice. The 1-bit result is returned
//            over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH            operand width (>= 2)
//   CHUNK            slice width per cycle (must divide WIDTH)
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset, clears every register
//   i_flush          synchronous abort of any in-flight operation
//   i_valid/o_ready  request handshake (accepted only in IDLE)
//   i_rs1, i_rs2     operands A and B, sampled on the accept edge only
//   i_cmp_operation  cmp_op_e encoding: EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5
//   o_valid/i_ready  result handshake (result held until taken)
//   o_cmp_result     comparison result, meaningful while o_valid is high
//   o_busy           high while an operation is in BUSY or DONE
// ============================================================================
module letc_core_iter_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic [2:0]       i_cmp_operation,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_cmp_result,
  output logic             o_busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_NCHUNK = WIDTH / CHUNK;
  // A single-slice configuration still needs a 1-bit index register.
  localparam int c_IDXW   = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

  localparam logic [c_IDXW-1:0] c_IDX_ZERO = '0;
  localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);
  localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(c_NCHUNK - 1);

  // cmp_op_e encodings
  localparam logic [2:0] c_CMP_EQ  = 3'd0;
  localparam logic [2:0] c_CMP_NE  = 3'd1;
  localparam logic [2:0] c_CMP_LT  = 3'd2;
  localparam logic [2:0] c_CMP_GE  = 3'd3;
  localparam logic [2:0] c_CMP_LTU = 3'd4;
  localparam logic [2:0] c_CMP_GEU = 3'd5;

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  r_rs1;
  logic [WIDTH-1:0]  r_rs2;
  logic [2:0]        r_op;
  logic [c_IDXW-1:0] r_idx;
  logic              r_result;

  // --------------------------------------------------------------------------
  // Slice extraction: element g holds bits [WIDTH-1-g*CHUNK -: CHUNK], so
  // element 0 is the most significant slice.
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] w_a_sl [c_NCHUNK];
  logic [CHUNK-1:0] w_b_sl [c_NCHUNK];

  for (genvar g = 0; g < c_NCHUNK; g++) begin : g_slice
    assign w_a_sl[g] = r_rs1[WIDTH-1-g*CHUNK -: CHUNK];
    assign w_b_sl[g] = r_rs2[WIDTH-1-g*CHUNK -: CHUNK];
  end

  // --------------------------------------------------------------------------
  // Slice compare and result mapping
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic             w_signed;
  logic             w_diff;
  logic             w_last;
  logic             w_eq;
  logic             w_lt;
  logic             w_res;

  always_comb begin
    w_sa     = w_a_sl[r_idx];
    w_sb     = w_b_sl[r_idx];
    // Signed ordering on the MSB slice: inverting both sign bits turns a
    // two's-complement compare into an unsigned one.
    w_signed = ((r_op == c_CMP_LT) || (r_op == c_CMP_GE)) && (r_idx == c_IDX_ZERO);
    w_sa[CHUNK-1] = w_sa[CHUNK-1] ^ w_signed;
    w_sb[CHUNK-1] = w_sb[CHUNK-1] ^ w_signed;

    w_diff = (w_sa != w_sb);
    w_last = (r_idx == c_IDX_LAST);
    // When no slice differs the operands are equal, so lt is forced low.
    w_eq   = !w_diff;
    w_lt   = w_diff && (w_sa < w_sb);

    case (r_op)
      c_CMP_EQ:  w_res = w_eq;
      c_CMP_NE:  w_res = !w_eq;
      c_CMP_LT:  w_res = w_lt;
      c_CMP_GE:  w_res = !w_lt;
      c_CMP_LTU: w_res = w_lt;
      c_CMP_GEU: w_res = !w_lt;
      default:   w_res = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        o_busy = 1'b1;
        if (w_diff || w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over any handshake in the same cycle.
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_result <= 1'b0;
    end else if (!i_flush) begin
      if ((r_state == S_IDLE) && i_valid) begin
        r_rs1 <= i_rs1;
        r_rs2 <= i_rs2;
        r_op  <= i_cmp_operation;
        r_idx <= c_IDX_ZERO;
      end
      if (r_state == S_BUSY) begin
        if (w_diff || w_last) begin
          r_result <= w_res;
        end else begin
          // Only advances below the last slice, so it never wraps.
          r_idx <= r_idx + c_IDX_ONE;
        end
      end
    end
  end

  assign o_cmp_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_letc_core_iter_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_letc_core_iter_comparator
// Purpose  : Self-checking bench for letc_core_iter_comparator. Three
//            instances: 32/8 (directed cases), 64/16 and 32/32 (random sweep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_letc_core_iter_comparator;

  localparam logic [2:0] c_EQ  = 3'd0;
  localparam logic [2:0] c_NE  = 3'd1;
  localparam logic [2:0] c_LT  = 3'd2;
  localparam logic [2:0] c_GE  = 3'd3;
  localparam logic [2:0] c_LTU = 3'd4;
  localparam logic [2:0] c_GEU = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  vin;
  logic [2:0]  rin;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [2:0]  op;
  logic [2:0]  ordy;
  logic [2:0]  oval;
  logic [2:0]  ores;
  logic [2:0]  obusy;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_res_q [$];
  int exp_lat_q [$];

  always #5 clk = ~clk;

  letc_core_iter_comparator #(.WIDTH(32), .CHUNK(8)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin[0]), .o_ready(ordy[0]),
    .i_rs1(rs1[31:0]), .i_rs2(rs2[31:0]), .i_cmp_operation(op), .o_valid(oval[0]),
    .i_ready(rin[0]), .o_cmp_result(ores[0]), .o_busy(obusy[0])
  );

  letc_core_iter_comparator #(.WIDTH(64), .CHUNK(16)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin[1]), .o_ready(ordy[1]),
    .i_rs1(rs1), .i_rs2(rs2), .i_cmp_operation(op), .o_valid(oval[1]),
    .i_ready(rin[1]), .o_cmp_result(ores[1]), .o_busy(obusy[1])
  );

  letc_core_iter_comparator #(.WIDTH(32), .CHUNK(32)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin[2]), .o_ready(ordy[2]),
    .i_rs1(rs1[31:0]), .i_rs2(rs2[31:0]), .i_cmp_operation(op), .o_valid(oval[2]),
    .i_ready(rin[2]), .o_cmp_result(ores[2]), .o_busy(obusy[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int sel);
    return (sel == 1) ? 64 : 32;
  endfunction

  function automatic int chk(input int sel);
    return (sel == 0) ? 8 : ((sel == 1) ? 16 : 32);
  endfunction

  // Reference compare on whole operands.
  function automatic bit ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] o, input int w);
    logic [63:0] am, bm;
    bit eq, lts, ltu;
    if (w == 32) begin
      am  = {32'h0, a[31:0]};
      bm  = {32'h0, b[31:0]};
      lts = $signed(a[31:0]) < $signed(b[31:0]);
    end else begin
      am  = a;
      bm  = b;
      lts = $signed(a) < $signed(b);
    end
    eq  = (am == bm);
    ltu = (am < bm);
    case (o)
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd2:    return lts;
      3'd3:    return !lts;
      3'd4:    return ltu;
      3'd5:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Expected latency: 2 + index of first differing slice, NCHUNK+1 if equal.
  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input int w, input int c);
    int n;
    logic [63:0] m;
    n = w / c;
    m = (c == 64) ? '1 : ((64'h1 << c) - 64'h1);
    for (int i = 0; i < n; i++) begin
      int sh;
      sh = w - (i + 1) * c;
      if (((a >> sh) & m) != ((b >> sh) & m)) return 2 + i;
    end
    return n + 1;
  endfunction

  // Starts at a negedge with the selected instance idle; returns at the
  // negedge right after the result handshake (instance idle again).
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] o, input int exp_lat, input int hold,
                        input string tag);
    int lat;
    bit er;
    int el;
    rs1 = a;
    rs2 = b;
    op  = o;
    vin[sel] = 1'b1;
    exp_res_q.push_back(ref_cmp(a, b, o, wid(sel)));
    exp_lat_q.push_back((exp_lat < 0) ? ref_lat(a, b, wid(sel), chk(sel)) : exp_lat);
    check({tag, "/ready"}, 64'(ordy[sel]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    vin[sel] = 1'b0;
    // Scramble inputs after accept; they must not matter.
    rs1 = ~a;
    rs2 = a ^ 64'h5A5A_A5A5_3C3C_C3C3;
    op  = o ^ 3'd1;
    check({tag, "/busy"}, 64'(obusy[sel]), 64'd1);
    lat = 1;
    while (!oval[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    er = exp_res_q.pop_front();
    el = exp_lat_q.pop_front();
    check({tag, "/latency"}, 64'(lat), 64'(el));
    check({tag, "/result"}, 64'(ores[sel]), 64'(er));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "/bp_valid"}, 64'(oval[sel]), 64'd1);
      check({tag, "/bp_result"}, 64'(ores[sel]), 64'(er));
      check({tag, "/bp_ready"}, 64'(ordy[sel]), 64'd0);
    end
    rin[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rin[sel] = 1'b0;
    check({tag, "/released"}, 64'(oval[sel]), 64'd0);
  endtask

  initial begin
    bit seen;
    rst   = 1'b1;
    flush = 1'b0;
    vin   = '0;
    rin   = '0;
    rs1   = '0;
    rs2   = '0;
    op    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst/ready", 64'(ordy[s]), 64'd1);
      check("rst/valid", 64'(oval[s]), 64'd0);
      check("rst/result", 64'(ores[s]), 64'd0);
      check("rst/busy", 64'(obusy[s]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on the 32/8 instance
    run_op(0, 64'h0101_0101, 64'hF0F0_F0F0, c_EQ, 2, 0, "eq_early");
    run_op(0, 64'hABCD_1234, 64'hABCD_1234, c_EQ, 5, 0, "eq_equal");
    run_op(0, 64'hFFFF_FFFF, 64'h0000_1234, c_LT,  2, 0, "sgn_lt");
    run_op(0, 64'hFFFF_FFFF, 64'h0000_1234, c_GE,  2, 0, "sgn_ge");
    run_op(0, 64'hFFFF_FFFF, 64'h0000_1234, c_LTU, 2, 0, "sgn_ltu");
    run_op(0, 64'hFFFF_FFFF, 64'h0000_1234, c_GEU, 2, 0, "sgn_geu");
    run_op(0, 64'h0000_1234, 64'h0000_ABCD, c_LT,  4, 0, "low_lt");
    run_op(0, 64'h0000_1234, 64'h0000_ABCD, c_GEU, 4, 0, "low_geu");
    run_op(0, 64'h8000_0000, 64'h7FFF_FFFF, c_LT,  2, 0, "min_lt");
    run_op(0, 64'h1234_5678, 64'h1234_5678, c_NE,  5, 0, "ne_equal");
    run_op(0, 64'h1234_5678, 64'h1234_5678, 3'd6, 5, 0, "undef6");
    run_op(0, 64'h0000_0001, 64'h0000_0002, 3'd7, 5, 0, "undef7");

    // Back-pressure, then an immediate back-to-back request
    run_op(0, 64'h0000_0005, 64'h0000_0003, c_GEU, 5, 4, "bp");
    run_op(0, 64'hFFFF_FFFF, 64'h0000_0001, c_LT,  2, 0, "b2b");

    // Flush in cycle 2 of an equal-operand EQ
    rs1 = 64'hABCD_1234;
    rs2 = 64'hABCD_1234;
    op  = c_EQ;
    vin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin[0] = 1'b0;
    check("flush/busy_c1", 64'(obusy[0]), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/ready_c3", 64'(ordy[0]), 64'd1);
    check("flush/valid_c3", 64'(oval[0]), 64'd0);
    check("flush/busy_c3", 64'(obusy[0]), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= oval[0];
    end
    check("flush/no_valid", 64'(seen), 64'd0);

    // Same with reset; the previous result (1) must be cleared
    vin[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid/ready", 64'(ordy[0]), 64'd1);
    check("rstmid/valid", 64'(oval[0]), 64'd0);
    check("rstmid/busy", 64'(obusy[0]), 64'd0);
    check("rstmid/result", 64'(ores[0]), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= oval[0];
    end
    check("rstmid/no_valid", 64'(seen), 64'd0);
    run_op(0, 64'h0000_0010, 64'h0000_0020, c_LTU, 5, 0, "post_rst");

    // Parameter sweep: 64/16 and 32/32 with random operands and ops
    for (int s = 1; s < 3; s++) begin
      for (int it = 0; it < 30; it++) begin
        logic [63:0] a, b, lo_mask;
        int n, k, lb;
        n  = wid(s) / chk(s);
        a  = {$urandom, $urandom};
        k  = $urandom_range(0, n);
        lb = wid(s) - k * chk(s);
        lo_mask = (lb >= 64) ? '1 : ((64'h1 << lb) - 64'h1);
        b  = (a & ~lo_mask) | ({$urandom, $urandom} & lo_mask);
        run_op(s, a, b, 3'($urandom_range(0, 5)), -1, 0, (s == 1) ? "sweep64" : "sweep32");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
